servo_pwm_driver: RTL
=====================

SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 SHALL provide parameter PRESCALE, default 196, meaning system clocks per PWM tick (>= 1).
REQ-002 SHALL provide parameter MIN_TICKS, default 255, meaning pulse width in ticks for angle 8'h00.
REQ-003 SHALL provide parameter PERIOD_TICKS, default 5102, meaning PWM frame length in ticks; legal only if PERIOD_TICKS > MIN_TICKS + 255 and PERIOD_TICKS <= 65535.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge, single clock domain.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  1 = generate frames, 0 = stop at the next frame boundary.
REQ-007 SHALL have port servo_angle  input  8  commanded position; 8'h00 = minimum pulse, 8'hFF = maximum pulse.
REQ-008 SHALL have port pwm_out  output  1  registered servo control pulse.
REQ-009 SHALL have port servo_cycle_done  output  1  one-clock strobe marking the last clock of each frame.

Function
REQ-010 SHALL implement states IDLE, PULSE and GAP.
REQ-011 SHALL contain a prescaler counter 0..PRESCALE-1; a tick is its terminal count; it resets to 0 at each frame start.
REQ-012 SHALL contain a 16-bit tick counter 0..PERIOD_TICKS-1, advancing on each tick and reset to 0 at each frame start.
REQ-013 SHALL start a frame on the clock edge where IDLE exits with enable=1, and on the edge after the last clock of a frame when enable=1.
REQ-014 SHALL latch servo_angle into an internal angle register only at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-015 SHALL compute pulse_ticks = MIN_TICKS + latched angle in 16-bit unsigned arithmetic, with no overflow under the REQ-003 constraint.
REQ-016 SHALL drive pwm_out=1 (PULSE) from the first clock of a frame for exactly pulse_ticks*PRESCALE clocks, then pwm_out=0 (GAP) for the remainder.
REQ-017 SHALL make every frame exactly PERIOD_TICKS*PRESCALE clocks long, independent of angle.
REQ-018 SHALL assert servo_cycle_done for exactly one clock: the last clock of the frame (tick counter = PERIOD_TICKS-1 and prescaler = PRESCALE-1), while pwm_out=0.
REQ-019 SHALL, if enable=0 during a frame, complete that frame unchanged (no truncated pulse), emit servo_cycle_done, then enter IDLE.
REQ-020 SHALL hold pwm_out=0 and servo_cycle_done=0 in IDLE; enable=1 in IDLE SHALL make the next clock the first clock of a new frame (pwm_out=1).
REQ-021 SHALL, if enable returns to 1 before the last clock of a frame, continue back-to-back frames with no IDLE gap.
REQ-022 SHALL treat angle 8'h00 and 8'hFF as ordinary values: the pulse is never 0 clocks and never the full frame.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, force state=IDLE, pwm_out=0, servo_cycle_done=0, prescaler=0, tick counter=0 and latched angle=8'h80.
REQ-024 SHALL apply reset mid-pulse or mid-gap at the next edge with no completion of the frame; after rst falls, behaviour follows REQ-020.

Verification (PRESCALE=2, MIN_TICKS=4, PERIOD_TICKS=300)
REQ-025 SHALL check: reset, enable=1, angle=8'h00 -> pwm_out high 8 clocks, low 592 clocks, servo_cycle_done on clock 600 of each frame, repeating.
REQ-026 SHALL check: angle=8'h80 -> high 264 clocks; angle=8'hFF -> high 518 clocks; frame stays 600 clocks.
REQ-027 SHALL check: angle changed 8'h00->8'hFF at clock 100 of a frame -> current frame high 8 clocks, next frame high 518 clocks.
REQ-028 SHALL check: enable dropped at clock 3 of a frame -> full 8-clock pulse, done strobe at clock 600, then pwm_out=0 indefinitely; enable re-raised -> pwm_out=1 on the next clock.
REQ-029 SHALL check: rst pulsed at clock 5 of a pulse -> pwm_out=0 and servo_cycle_done=0 on the next edge; after release, a fresh full-length frame.
REQ-030 SHALL check: closed loop with servo_fsm (start 8'h7E, end 8'h82, move_en=1) -> latched angle sequence 80,7F,7E,7F,80,81,82,81,... one step per frame.

Source files
------------

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator. Each frame is PERIOD_TICKS ticks of PRESCALE clocks.
// The pulse is high for (MIN_TICKS + angle) ticks at the start of the frame and low after that.
// The angle is sampled only when a frame starts.
// Dropping enable lets the current frame finish cleanly, then the block parks in idle.
module servo_pwm_driver #(
    parameter int unsigned PRESCALE     = 196,
    parameter int unsigned MIN_TICKS    = 255,
    parameter int unsigned PERIOD_TICKS = 5102
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] servo_angle,
    output logic       pwm_out,
    output logic       servo_cycle_done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);
    localparam logic [15:0]   TickLast = 16'(PERIOD_TICKS - 1);
    localparam logic [15:0]   MinTicks = 16'(MIN_TICKS);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     tick_q, tick_d;
    logic [7:0]      angle_q, angle_d;
    logic            pwm_q, pwm_d;
    logic            done_q, done_d;
    logic            frame_last;
    logic            frame_start;
    logic [15:0]     pulse_ticks;

    assign frame_last = (state_q != StIdle) && (presc_q == PresLast) && (tick_q == TickLast);

    // State and counter registers; outputs are registered so they are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            presc_q <= '0;
            tick_q  <= '0;
            angle_q <= 8'h80;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            angle_q <= angle_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    // Next-state: frame sequencing, counter advance and pulse/gap classification
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        tick_d      = tick_q;
        angle_d     = angle_q;
        frame_start = 1'b0;
        pulse_ticks = '0;

        unique case (state_q)
            StIdle: begin
                if (enable) frame_start = 1'b1;
            end
            StPulse, StGap: begin
                if (frame_last) begin
                    if (enable) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = StIdle;
                        presc_d = '0;
                        tick_d  = '0;
                    end
                end else if (presc_q == PresLast) begin
                    presc_d = '0;
                    tick_d  = tick_q + 16'd1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_start) begin
            state_d = StPulse;
            presc_d = '0;
            tick_d  = '0;
            angle_d = servo_angle;
        end

        // Pulse width uses the angle that applies to the clock being entered
        pulse_ticks = MinTicks + {8'h00, angle_d};
        if (state_d != StIdle) begin
            state_d = (tick_d < pulse_ticks) ? StPulse : StGap;
        end
    end

    // Output decode from the state being entered, registered on the next edge
    always_comb begin
        pwm_d  = (state_d == StPulse);
        done_d = (state_d != StIdle) && (tick_d == TickLast) && (presc_d == PresLast);
    end

    assign pwm_out          = pwm_q;
    assign servo_cycle_done = done_q;

endmodule
